// File: rtl/vsd_prog_loader.sv
// ============================================================================
// vsd_prog_loader
// ----------------------------------------------------------------------------
// Loads the 256x32 instruction SRAM of vsdmemsoc through its init port from
// a length-prefixed byte stream. The first byte is the word count N (0 means
// 256). Every following group of four bytes is packed little-endian into a
// 32-bit word. Each word is written with a one-cycle init_en strobe at an
// auto-incrementing address, starting at 0.
//
// Optional feature (macro LOADER_CHECKSUM_EN):
//   After the last word, one more byte is accepted and compared with the
//   8-bit wrap-around sum of all data bytes. A mismatch sets the sticky err
//   flag. Without the macro there is no checksum phase and err is tied to 0.
//
// Handshake: a byte is transferred in any cycle where rx_valid && rx_ready.
// rx_data is only sampled on that transfer. rx_ready does not depend on
// rx_valid. A held rx_valid with rx_ready low is simply stalled, never lost.
//
// Ports:
//   CLK          in   clock for all state
//   reset        in   synchronous, active-high reset
//   rx_valid     in   byte source offers rx_data
//   rx_data      in   [7:0] incoming byte
//   rx_ready     out  loader accepts a byte this cycle
//   init_en      out  one-cycle write strobe to the SoC init port
//   init_addr    out  [7:0] word address, valid while init_en=1
//   init_data    out  [31:0] packed word, valid while init_en=1
//   busy         out  load in progress
//   done         out  sticky, load finished
//   err          out  sticky, checksum mismatch (checksum build only)
//   dbg_state_o  out  [2:0] current FSM state, for debug and checkers
// ============================================================================
module vsd_prog_loader (
    input  logic        CLK,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        init_en,
    output logic [7:0]  init_addr,
    output logic [31:0] init_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHK   = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q;
    logic [8:0]  total_q;      // words to load, 1..256
    logic [7:0]  addr_q;       // address of the word being assembled
    logic [1:0]  idx_q;        // byte lane for the next data byte
    logic [31:0] word_q;       // partially assembled word
    logic        init_en_q;
    logic [7:0]  init_addr_q;
    logic [31:0] init_data_q;
    logic        busy_q;
    logic        done_q;

    logic        accept;
    logic        last_word;
    logic [31:0] word_d;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_q;
    logic [7:0]  sum_d;
    logic        err_q;
`endif

    // Gating with reset keeps rx_ready low in the reset cycle itself,
    // before the synchronous reset has reached the state register.
    assign rx_ready = !reset && ((state_q == S_IDLE) || (state_q == S_LOAD)
`ifdef LOADER_CHECKSUM_EN
                                 || (state_q == S_CHK)
`endif
                                );

    assign accept = rx_valid && rx_ready;

    // Address counts from 0, so word k is the last one when k+1 == total.
    assign last_word = (({1'b0, addr_q} + 9'd1) == total_q);

    // Drop the incoming byte into its little-endian lane.
    always_comb begin
        word_d = word_q;
        case (idx_q)
            2'd0:    word_d[7:0]   = rx_data;
            2'd1:    word_d[15:8]  = rx_data;
            2'd2:    word_d[23:16] = rx_data;
            default: word_d[31:24] = rx_data;
        endcase
    end

`ifdef LOADER_CHECKSUM_EN
    assign sum_d = sum_q + rx_data;
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_IDLE;
            total_q     <= 9'd0;
            addr_q      <= 8'd0;
            idx_q       <= 2'd0;
            word_q      <= 32'd0;
            init_en_q   <= 1'b0;
            init_addr_q <= 8'd0;
            init_data_q <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= 8'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            init_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        total_q <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        addr_q  <= 8'd0;
                        idx_q   <= 2'd0;
                        word_q  <= 32'd0;
                        busy_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        sum_q   <= 8'd0;
`endif
                        state_q <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        word_q <= word_d;
                        idx_q  <= idx_q + 2'd1;   // wraps to 0 after lane 3
`ifdef LOADER_CHECKSUM_EN
                        sum_q  <= sum_d;
`endif
                        if (idx_q == 2'd3) begin
                            init_en_q   <= 1'b1;
                            init_addr_q <= addr_q;
                            init_data_q <= word_d;
                            state_q     <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q <= S_CHK;
`else
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
`endif
                    end else begin
                        addr_q  <= addr_q + 8'd1;
                        idx_q   <= 2'd0;
                        state_q <= S_LOAD;
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        err_q   <= (rx_data != sum_q);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
`endif

                S_DONE: begin
                    // Terminal until reset; bytes are held off by rx_ready=0.
                    state_q <= S_DONE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign init_en     = init_en_q;
    assign init_addr   = init_addr_q;
    assign init_data   = init_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

`ifdef LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
